// File: rtl/led_sched_pkg.sv
// Shared constants and FSM encoding for the LED pattern scheduler.
package led_sched_pkg;
  localparam int N_REQ        = 4;
  localparam int PAT_LEN      = 12;
  localparam int STEP_W       = 4;
  localparam int GID_W        = 2;
  localparam int REP_W        = 2;
  localparam int TICK_DIV_DEF = 5000000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_GAP  = 2'd2
  } state_e;
endpackage

// File: rtl/led_pattern_sched_if.sv
// Requester-side bus of the scheduler: requests/patterns in, grant/status out.
interface led_pattern_sched_if #(
  parameter int N_REQ   = led_sched_pkg::N_REQ,
  parameter int PAT_LEN = led_sched_pkg::PAT_LEN,
  parameter int REP_W   = led_sched_pkg::REP_W
);
  import led_sched_pkg::*;

  logic [N_REQ-1:0]         iREQ;
  logic [N_REQ*PAT_LEN-1:0] iPAT;
  logic [N_REQ*REP_W-1:0]   iREP;
  logic [N_REQ-1:0]         oACK;
  logic [N_REQ-1:0]         oDONE;
  logic                     oBUSY;
  logic [GID_W-1:0]         oGRANT_ID;
  logic [STEP_W-1:0]        oSTEP;
  logic                     oLED;

  // Scheduler side
  modport slave (
    input  iREQ, iPAT, iREP,
    output oACK, oDONE, oBUSY, oGRANT_ID, oSTEP, oLED
  );

  // Requester side
  modport master (
    output iREQ, iPAT, iREP,
    input  oACK, oDONE, oBUSY, oGRANT_ID, oSTEP, oLED
  );
endinterface

// File: rtl/tick_gen.sv
// Step prescaler: counts 0..TICK_DIV-1 and flags the last cycle of each step.
// Held at zero while iCLR is high so the first step after a grant is full length.
module tick_gen #(
  parameter int TICK_DIV = 4
) (
  input  logic iCLK,
  input  logic iRST,
  input  logic iCLR,
  output logic oTICK
);
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: wrap at the end of a step, hold at zero while cleared
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (iCLR || cnt_q == LAST) cnt_d = '0;
  end

  // Counter register
  always_ff @(posedge iCLK) begin
    if (iRST) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign oTICK = !iCLR && (cnt_q == LAST);
endmodule

// File: rtl/led_pattern_sched.sv
// Round-robin LED pattern scheduler: grants one requester at a time, plays its
// pattern (r+1) times at one step per TICK_DIV cycles, then a one-step dark gap.
module led_pattern_sched
  import led_sched_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEF,
  parameter int N_REQ    = led_sched_pkg::N_REQ,
  parameter int PAT_LEN  = led_sched_pkg::PAT_LEN
) (
  input  logic                iCLK,
  input  logic                iRST,
  led_pattern_sched_if.slave  bus
);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(PAT_LEN - 1);
  localparam logic [GID_W-1:0]  LAST_REQ  = GID_W'(N_REQ - 1);

  state_e              state_q, state_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [REP_W-1:0]    rep_q, rep_d;
  logic [PAT_LEN-1:0]  pat_q, pat_d;
  logic [GID_W-1:0]    ptr_q, ptr_d, gid_q, gid_d, pick;
  logic [N_REQ-1:0]    ack_q, ack_d, done_q, done_d;
  logic                busy_q, busy_d, led_q, led_d;
  logic                tick;

  logic [PAT_LEN-1:0]  pat_arr [N_REQ];
  logic [REP_W-1:0]    rep_arr [N_REQ];

  for (genvar k = 0; k < N_REQ; k++) begin : g_unpack
    assign pat_arr[k] = bus.iPAT[k*PAT_LEN +: PAT_LEN];
    assign rep_arr[k] = bus.iREP[k*REP_W +: REP_W];
  end

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .iCLK  (iCLK),
    .iRST  (iRST),
    .iCLR  (state_q == S_IDLE),
    .oTICK (tick)
  );

  // Round-robin pick: first requester at or after ptr_q (descending loop so
  // the lowest offset wins)
  always_comb begin
    int s;
    logic [GID_W-1:0] idx;
    pick = '0;
    s    = 0;
    idx  = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      s   = (int'(ptr_q) + i) % N_REQ;
      idx = GID_W'(s);
      if (bus.iREQ[idx]) pick = idx;
    end
  end

  // FSM next state and registered-output precompute
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    rep_d   = rep_q;
    pat_d   = pat_q;
    ptr_d   = ptr_q;
    gid_d   = gid_q;
    ack_d   = '0;
    done_d  = '0;
    unique case (state_q)
      S_IDLE: begin
        if (|bus.iREQ) begin
          state_d     = S_PLAY;
          step_d      = '0;
          pat_d       = pat_arr[pick];
          rep_d       = rep_arr[pick];
          gid_d       = pick;
          ack_d[pick] = 1'b1;
          ptr_d       = (pick == LAST_REQ) ? '0 : pick + 1'b1;
        end
      end
      S_PLAY: begin
        if (tick) begin
          if (step_q == LAST_STEP) begin
            step_d = '0;
            if (rep_q != '0) rep_d   = rep_q - 1'b1;
            else             state_d = S_GAP;
          end else begin
            step_d = step_q + 1'b1;
          end
        end
      end
      S_GAP: begin
        if (tick) begin
          state_d       = S_IDLE;
          done_d[gid_q] = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
    led_d  = (state_d == S_PLAY) ? pat_d[step_d] : 1'b0;
  end

  // State and output registers; reset aborts any playback silently
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q <= S_IDLE;
      step_q  <= '0;
      rep_q   <= '0;
      pat_q   <= '0;
      ptr_q   <= '0;
      gid_q   <= '0;
      ack_q   <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      led_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      rep_q   <= rep_d;
      pat_q   <= pat_d;
      ptr_q   <= ptr_d;
      gid_q   <= gid_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      led_q   <= led_d;
    end
  end

  assign bus.oACK      = ack_q;
  assign bus.oDONE     = done_q;
  assign bus.oBUSY     = busy_q;
  assign bus.oGRANT_ID = gid_q;
  assign bus.oSTEP     = (state_q == S_PLAY) ? step_q : '0;
  assign bus.oLED      = led_q;
endmodule

// File: tb/tb_led_pattern_sched.sv
// Bench for led_pattern_sched with TICK_DIV=4. Expected behaviour is derived
// per grant from the playback rules: grant = first requester from the
// round-robin pointer, LED(c) = pattern[(c/4)%12] for c < 48*(r+1), then a
// 4-cycle dark gap, then oDONE.
module tb_led_pattern_sched;
  localparam int TD = 4;
  localparam int NR = 4;

  logic clk = 1'b0;
  logic rst;
  int   vecs = 0;
  int   errs = 0;
  int   m_ptr = 0;
  int   mid1_c = -1, mid2_c = -1;
  logic [3:0] mid1_v = '0, mid2_v = '0;

  led_pattern_sched_if #(.N_REQ(4), .PAT_LEN(12), .REP_W(2)) bus ();

  led_pattern_sched #(.TICK_DIV(TD), .N_REQ(4), .PAT_LEN(12)) dut (
    .iCLK (clk),
    .iRST (rst),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, observed running expected done");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ack"},  32'(bus.oACK), 0);
    chk({tag, "_done"}, 32'(bus.oDONE), 0);
    chk({tag, "_busy"}, 32'(bus.oBUSY), 0);
    chk({tag, "_gid"},  32'(bus.oGRANT_ID), 0);
    chk({tag, "_step"}, 32'(bus.oSTEP), 0);
    chk({tag, "_led"},  32'(bus.oLED), 0);
  endtask

  task automatic rand_inputs();
    bus.iPAT = 48'({$urandom(), $urandom()});
    bus.iREP = 8'($urandom());
  endtask

  // One grant from request to oDONE, checked cycle by cycle against the model.
  task automatic run_grant(input bit hold, input int abort_step);
    int k, w, busy, st;
    logic [11:0] p;
    int r;
    k = -1;
    for (int i = 0; i < NR; i++) begin
      int j;
      j = (m_ptr + i) % NR;
      if (k < 0 && bus.iREQ[j]) k = j;
    end
    if (k < 0) k = 0;
    w = 0;
    do begin
      step();
      w++;
    end while (bus.oACK == '0 && w < 8);
    chk("ack_latency", w, 1);
    chk("ack", 32'(bus.oACK), 32'(1 << k));
    chk("grant_id", 32'(bus.oGRANT_ID), k);
    if (bus.oACK == '0) return;
    p     = 12'(bus.iPAT >> (k * 12));
    r     = int'(2'(bus.iREP >> (k * 2)));
    m_ptr = (k + 1) % NR;
    if (!hold) bus.iREQ[k] = 1'b0;
    busy = (r + 1) * 12 * TD + TD;
    for (int c = 0; c < busy; c++) begin
      if (c > 0) step();
      st = (c < (r + 1) * 12 * TD) ? (c / TD) % 12 : 0;
      chk("busy", 32'(bus.oBUSY), 1);
      chk("step", 32'(bus.oSTEP), st);
      chk("led", 32'(bus.oLED), (c < (r + 1) * 12 * TD) ? int'((p >> st) & 12'h1) : 0);
      chk("done_early", 32'(bus.oDONE), 0);
      if (c > 0) chk("ack_extra", 32'(bus.oACK), 0);
      if (abort_step >= 0 && c == abort_step * TD) begin
        rst      = 1'b1;
        bus.iREQ = 4'b0101;
        return;
      end
      if (c == 5) rand_inputs();
      if (c == mid1_c) bus.iREQ = mid1_v;
      if (c == mid2_c) bus.iREQ = mid2_v;
    end
    step();
    chk("done", 32'(bus.oDONE), 32'(1 << k));
    chk("done_busy", 32'(bus.oBUSY), 0);
    chk("done_led", 32'(bus.oLED), 0);
    chk("done_step", 32'(bus.oSTEP), 0);
    chk("done_ack", 32'(bus.oACK), 0);
    chk("done_gid", 32'(bus.oGRANT_ID), k);
  endtask

  initial begin
    rst      = 1'b1;
    bus.iREQ = '0;
    bus.iPAT = '0;
    bus.iREP = '0;
    repeat (3) step();
    chk_all_zero("reset");
    rst = 1'b0;
    step();
    chk_all_zero("idle");

    // Single request, pattern 0x429, one play; requester 1 pulses and withdraws
    rand_inputs();
    bus.iPAT[11:0] = 12'h429;
    bus.iREP[1:0]  = 2'd0;
    bus.iREQ = 4'b0001;
    mid1_c = 10; mid1_v = 4'b0010;
    mid2_c = 20; mid2_v = 4'b0000;
    run_grant(1'b0, -1);
    mid1_c = -1; mid2_c = -1;
    repeat (3) begin
      step();
      chk("withdraw_ack", 32'(bus.oACK), 0);
      chk("withdraw_busy", 32'(bus.oBUSY), 0);
    end

    // Fairness: requester 0 re-requests alongside 1 during its own playback
    bus.iREQ = 4'b0001;
    mid1_c = 10; mid1_v = 4'b0011;
    run_grant(1'b0, -1);
    mid1_c = -1;
    run_grant(1'b0, -1);
    run_grant(1'b0, -1);

    // Repeat count 3: four plays then the gap
    rand_inputs();
    bus.iREP[5:4] = 2'd3;
    bus.iREQ = 4'b0100;
    run_grant(1'b0, -1);

    // Reset at step 5, simultaneous requests 0 and 2 must wait for reset release
    rand_inputs();
    bus.iREQ = 4'b0100;
    run_grant(1'b0, 5);
    step();
    chk_all_zero("abort");
    rst   = 1'b0;
    m_ptr = 0;
    run_grant(1'b0, -1);
    run_grant(1'b0, -1);

    // All requesters held high from a fresh reset: 0,1,2,3,0 back-to-back
    rst = 1'b1;
    step();
    rst   = 1'b0;
    m_ptr = 0;
    rand_inputs();
    bus.iREQ = 4'b1111;
    repeat (5) run_grant(1'b1, -1);
    bus.iREQ = '0;

    // Random request mixes with idle gaps
    repeat (6) begin
      int idle;
      bus.iREQ = '0;
      idle = int'($urandom_range(0, 3));
      for (int i = 0; i < idle; i++) begin
        step();
        chk("rand_idle_ack", 32'(bus.oACK), 0);
      end
      rand_inputs();
      bus.iREQ = 4'($urandom_range(1, 15));
      run_grant(1'b0, -1);
    end
    bus.iREQ = '0;

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
